// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised 2R/1W register file with write bypass and pending-write scoreboard
//
// Purpose:
//   Architectural register file between decode and writeback. Reads are
//   combinational, and a same-cycle write is bypassed onto the read ports.
//   Each register has a small saturating pending-write counter. Decode
//   reserves a register here. Writeback retires one reservation when it
//   writes with i_release set.
//
// Ports:
//   i_clk          clock, all state updates on posedge
//   i_reset_n      synchronous active-low reset (clears data and counters)
//   i_load         write enable
//   i_dest         write register index
//   i_in           write data
//   i_release      with i_load: retire one reservation of i_dest
//   i_reserve      claim a pending write to i_reserve_reg
//   i_reserve_reg  register being reserved
//   o_reserve_ok   reservation accepted this cycle (combinational)
//   i_src_a/b      read indices
//   o_reg_a/b      read data (combinational, bypassed)
//   o_busy_a/b     registered pending count of src_a/src_b is non-zero
//   o_any_busy     any register has a non-zero pending count
module regfile_sb #(
   parameter int DATA_W  = 16,
   parameter int NREGS   = 8,
   parameter int CNT_W   = 2,
   parameter int R0_ZERO = 0,
   localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_dest,
   input  logic [DATA_W-1:0] i_in,
   input  logic              i_release,
   input  logic              i_reserve,
   input  logic [ADDR_W-1:0] i_reserve_reg,
   output logic              o_reserve_ok,
   input  logic [ADDR_W-1:0] i_src_a,
   input  logic [ADDR_W-1:0] i_src_b,
   output logic [DATA_W-1:0] o_reg_a,
   output logic [DATA_W-1:0] o_reg_b,
   output logic              o_busy_a,
   output logic              o_busy_b,
   output logic              o_any_busy
);

   // Storage covers the full index space so every index value is a legal
   // array element. Entries at or above NREGS are never written or
   // reserved, so they stay zero.
   localparam int                DEPTH   = 1 << ADDR_W;
   localparam int unsigned       NR_U    = NREGS;
   localparam logic [ADDR_W:0]   LP_NREGS = NR_U[ADDR_W:0];
   localparam bit                LP_R0   = (R0_ZERO != 0);
   localparam logic [CNT_W-1:0]  LP_MAX  = '1;
   localparam logic [CNT_W-1:0]  LP_ONE  = 1;
   localparam logic [ADDR_W-1:0] LP_ZERO = '0;

   logic [DATA_W-1:0] r_data [0:DEPTH-1];
   logic [CNT_W-1:0]  r_cnt  [0:DEPTH-1];

   logic              w_dest_ok;
   logic              w_src_a_ok;
   logic              w_src_b_ok;
   logic              w_rsv_in_range;
   logic              w_wr_en;
   logic              w_rsv_dec;
   logic [DEPTH-1:0]  w_inc;
   logic [DEPTH-1:0]  w_dec;
   logic [DEPTH-1:0]  w_nonzero;

   // An index is readable when it is in range and is not a hardwired-zero r0.
   assign w_dest_ok      = ({1'b0, i_dest} < LP_NREGS) && !(LP_R0 && i_dest == LP_ZERO);
   assign w_src_a_ok     = ({1'b0, i_src_a} < LP_NREGS) && !(LP_R0 && i_src_a == LP_ZERO);
   assign w_src_b_ok     = ({1'b0, i_src_b} < LP_NREGS) && !(LP_R0 && i_src_b == LP_ZERO);
   assign w_rsv_in_range = ({1'b0, i_reserve_reg} < LP_NREGS);
   assign w_wr_en        = i_load && w_dest_ok;

   // A retirement of the reserved register in the same cycle frees a slot.
   // Because of that, a counter at max can still accept the reservation.
   assign w_rsv_dec = i_load && i_release && (i_dest == i_reserve_reg) &&
                      (r_cnt[i_reserve_reg] != '0);

   assign o_reserve_ok = !(LP_R0 && i_reserve_reg == LP_ZERO) &&
                         ((r_cnt[i_reserve_reg] != LP_MAX) || w_rsv_dec);

   // The bypass wins over stored data. A disabled index (r0 when hardwired,
   // or out of range) always reads zero.
   always_comb begin
      o_reg_a = '0;
      if (w_src_a_ok) begin
         if (i_load && i_dest == i_src_a) o_reg_a = i_in;
         else                             o_reg_a = r_data[i_src_a];
      end
   end

   always_comb begin
      o_reg_b = '0;
      if (w_src_b_ok) begin
         if (i_load && i_dest == i_src_b) o_reg_b = i_in;
         else                             o_reg_b = r_data[i_src_b];
      end
   end

   // Busy comes from the registered counters only. A release in the same
   // cycle shows up one cycle later.
   assign o_busy_a   = ({1'b0, i_src_a} < LP_NREGS) && (r_cnt[i_src_a] != '0);
   assign o_busy_b   = ({1'b0, i_src_b} < LP_NREGS) && (r_cnt[i_src_b] != '0);
   assign o_any_busy = |w_nonzero;

   always_comb begin
      w_inc     = '0;
      w_dec     = '0;
      w_nonzero = '0;
      for (int r = 0; r < DEPTH; r++) begin
         w_inc[r]     = i_reserve && o_reserve_ok && w_rsv_in_range &&
                        (i_reserve_reg == r[ADDR_W-1:0]);
         w_dec[r]     = i_load && i_release && (i_dest == r[ADDR_W-1:0]) &&
                        (r_cnt[r] != '0);
         w_nonzero[r] = (r_cnt[r] != '0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_data[r] <= '0;
            r_cnt[r]  <= '0;
         end
      end else begin
         if (w_wr_en) r_data[i_dest] <= i_in;
         for (int r = 0; r < DEPTH; r++) begin
            if (w_inc[r] && !w_dec[r])      r_cnt[r] <= r_cnt[r] + LP_ONE;
            else if (w_dec[r] && !w_inc[r]) r_cnt[r] <= r_cnt[r] - LP_ONE;
         end
      end
   end

endmodule
